// File: rtl/bpu_pred.sv
// Fetch-stage branch predictor: 2-bit BHT for conditional branches, direct jal targets,
// and an optional return-address stack enabled by defining YSYX_23060251_RAS_EN.
module bpu_pred #(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [31:0]     inst_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            if_valid_i,
    output logic [XLEN-1:0] pred_pc_o,
    output logic            pred_taken_o,
    input  logic            upd_valid_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic            upd_taken_i,
    input  logic            flush_i
);

    localparam int IDXW = $clog2(BHT_DEPTH);

    logic [6:0]      opcode;
    logic            is_br;
    logic            is_jal;
    logic            is_jalr;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] pc_plus4;
    logic [IDXW-1:0] lk_idx;
    logic [IDXW-1:0] up_idx;

    assign opcode   = inst_i[6:0];
    assign is_br    = (opcode == 7'b1100011);
    assign is_jal   = (opcode == 7'b1101111);
    assign is_jalr  = (opcode == 7'b1100111);
    assign imm_b    = {{(XLEN-12){inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_j    = {{(XLEN-20){inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
    assign pc_plus4 = pc_i + XLEN'(4);
    assign lk_idx   = pc_i[IDXW+1:2];
    assign up_idx   = upd_pc_i[IDXW+1:2];

    logic unused_upd_bits;
    assign unused_upd_bits = ^{upd_pc_i[1:0], upd_pc_i[XLEN-1:IDXW+2]};

    // Branch history table: saturating 2-bit counters, lookup reads the registered value only.
    logic [1:0] bht_q [BHT_DEPTH];
    logic [1:0] bht_d [BHT_DEPTH];

    always_comb begin
        bht_d = bht_q;
        if (upd_valid_i) begin
            if (upd_taken_i) begin
                if (bht_q[up_idx] != 2'b11) bht_d[up_idx] = bht_q[up_idx] + 2'b01;
            end else begin
                if (bht_q[up_idx] != 2'b00) bht_d[up_idx] = bht_q[up_idx] - 2'b01;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b01;
        end else begin
            bht_q <= bht_d;
        end
    end

`ifdef YSYX_23060251_RAS_EN
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic [XLEN-1:0] ras_d [RAS_DEPTH];
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   ptr_inc, ptr_dec;
    logic [4:0]      rd, rs1;
    logic            rd_link, rs1_link;
    logic            ras_push, ras_pop, ras_empty;

    assign rd        = inst_i[11:7];
    assign rs1       = inst_i[19:15];
    assign rd_link   = (rd == 5'd1) || (rd == 5'd5);
    assign rs1_link  = (rs1 == 5'd1) || (rs1 == 5'd5);
    assign ras_push  = (is_jal || is_jalr) && rd_link;
    assign ras_pop   = is_jalr && rs1_link && !(rd_link && (rd == rs1));
    assign ras_empty = (cnt_q == '0);
    // ptr_q points at the next free slot; the top of stack sits one below it, circularly.
    assign ptr_inc   = (ptr_q == PW'(RAS_DEPTH - 1)) ? '0 : ptr_q + PW'(1);
    assign ptr_dec   = (ptr_q == '0) ? PW'(RAS_DEPTH - 1) : ptr_q - PW'(1);

    always_comb begin
        ras_d = ras_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            ptr_d = '0;
            cnt_d = '0;
        end else if (if_valid_i) begin
            if (ras_pop && ras_push && !ras_empty) begin
                ras_d[ptr_dec] = pc_plus4;
            end else if (ras_push) begin
                ras_d[ptr_q] = pc_plus4;
                ptr_d        = ptr_inc;
                if (cnt_q != CW'(RAS_DEPTH)) cnt_d = cnt_q + CW'(1);
            end else if (ras_pop && !ras_empty) begin
                ptr_d = ptr_dec;
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        ras_q <= ras_d;
    end
`else
    logic unused_ras_ctl;
    assign unused_ras_ctl = ^{flush_i, if_valid_i};
`endif

    always_comb begin
        pred_pc_o    = pc_plus4;
        pred_taken_o = 1'b0;
        if (is_br) begin
            if (bht_q[lk_idx][1]) begin
                pred_pc_o    = pc_i + imm_b;
                pred_taken_o = 1'b1;
            end
        end else if (is_jal) begin
            pred_pc_o    = pc_i + imm_j;
            pred_taken_o = 1'b1;
        end
`ifdef YSYX_23060251_RAS_EN
        else if (ras_pop && !ras_empty) begin
            pred_pc_o    = ras_q[ptr_dec];
            pred_taken_o = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_bpu_pred.sv
// Directed bench for bpu_pred: per-cycle vector table for BHT/decode behaviour plus
// hand-written return-stack sequences (RAS checks track YSYX_23060251_RAS_EN).
module tb_bpu_pred;

    localparam logic [31:0] P    = 32'h8000_0000;
    localparam logic [31:0] B0   = 32'h0000_0863; // beq x0,x0,+16
    localparam logic [31:0] BM8  = 32'hFE00_0CE3; // beq x0,x0,-8
    localparam logic [31:0] JM8  = 32'hFF9F_F0EF; // jal x1,-8
    localparam logic [31:0] JP8  = 32'h0080_00EF; // jal x1,+8
    localparam logic [31:0] J5P8 = 32'h0080_02EF; // jal x5,+8
    localparam logic [31:0] ADDI = 32'h0031_00B3; // add x1,x2,x3
    localparam logic [31:0] RET  = 32'h0000_8067; // jalr x0,0(x1)
    localparam logic [31:0] RET5 = 32'h0002_8067; // jalr x0,0(x5)
    localparam logic [31:0] JR11 = 32'h0000_80E7; // jalr x1,0(x1)
    localparam logic [31:0] JR15 = 32'h0002_80E7; // jalr x1,0(x5)

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] inst_i, pc_i, upd_pc_i, pred_pc_o;
    logic        if_valid_i, upd_valid_i, upd_taken_i, flush_i, pred_taken_o;

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        rst;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] exp_pc;
        logic        exp_tk;
    } vec_t;
    vec_t tbl[$];

    bpu_pred #(.XLEN(32), .BHT_DEPTH(64), .RAS_DEPTH(4)) dut (
        .clock(clock), .reset(reset), .inst_i(inst_i), .pc_i(pc_i),
        .if_valid_i(if_valid_i), .pred_pc_o(pred_pc_o), .pred_taken_o(pred_taken_o),
        .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
        .flush_i(flush_i)
    );

    always #5 clock = ~clock;

    task automatic add(input logic rst, input logic uv, input logic [31:0] upc, input logic ut,
                       input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] epc, input logic etk);
        vec_t v;
        v = '{rst, uv, upc, ut, inst, pc, epc, etk};
        tbl.push_back(v);
    endtask

    task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic ifv,
                         input logic fl, input logic rst);
        inst_i = inst; pc_i = pc; if_valid_i = ifv; flush_i = fl; reset = rst;
        upd_valid_i = 1'b0; upd_pc_i = '0; upd_taken_i = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] epc, input logic etk);
        #3;
        n_vec++;
        if (pred_pc_o !== epc || pred_taken_o !== etk) begin
            n_bad++;
            $display("FAIL %s: pred_pc_o=%h pred_taken_o=%b, required %h %b",
                     name, pred_pc_o, pred_taken_o, epc, etk);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        drive(ADDI, '0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // rst, uv, upc, ut, inst, pc, exp_pc, exp_tk
        add(0, 1, P,        1, B0,   P,         P + 32'h04, 0); // reset value, no bypass
        add(0, 1, P,        1, B0,   P,         P + 32'h10, 1);
        add(0, 1, P,        0, B0,   P,         P + 32'h10, 1);
        add(0, 1, P,        0, B0,   P,         P + 32'h10, 1);
        add(0, 1, P,        0, B0,   P,         P + 32'h04, 0);
        add(0, 1, P,        0, B0,   P,         P + 32'h04, 0);
        add(0, 1, P,        1, B0,   P,         P + 32'h04, 0); // counter held at 0
        add(0, 0, 0,        0, B0,   P,         P + 32'h04, 0);
        add(0, 0, 0,        0, JM8,  P + 32'h100, P + 32'hF8, 1);
        add(0, 0, 0,        0, ADDI, P + 32'h200, P + 32'h204, 0);
        add(0, 1, P + 32'h100, 1, B0, P + 32'h100, P + 32'h104, 0);
        add(0, 1, P + 32'h4, 1, B0,  P,         P + 32'h10, 1); // 0x100 aliases index 0
        add(0, 0, 0,        0, B0,   P + 32'h4, P + 32'h14, 1);
        add(0, 0, 0,        0, BM8,  32'h0,     32'hFFFF_FFF8, 1);
        add(0, 0, 0,        0, JP8,  32'hFFFF_FFFC, 32'h0000_0004, 1);
        add(0, 0, 0,        0, ADDI, 32'hFFFF_FFFC, 32'h0, 0);
        add(0, 0, 0,        0, RET,  P + 32'h300, P + 32'h304, 0);
        add(0, 0, 0,        0, JR11, P + 32'h400, P + 32'h404, 0);
        add(0, 0, 0,        0, BM8,  P + 32'h8, P + 32'hC, 0);
        add(1, 1, P,        1, B0,   P,         P + 32'h10, 1); // reset beats update
        add(0, 0, 0,        0, B0,   P,         P + 32'h04, 0);
        add(0, 1, P + 32'h8, 1, B0,  P + 32'h4, P + 32'h08, 0);
        add(0, 1, P + 32'h8, 1, B0,  P + 32'h8, P + 32'h18, 1);
        add(0, 1, P + 32'h8, 1, B0,  P + 32'h8, P + 32'h18, 1);
        add(0, 1, P + 32'h8, 0, B0,  P + 32'h8, P + 32'h18, 1); // saturated at 3
        add(0, 0, 0,        0, B0,   P + 32'h8, P + 32'h18, 1);
        add(0, 1, P + 32'h8, 0, B0,  P + 32'h8, P + 32'h18, 1);
        add(0, 0, 0,        0, B0,   P + 32'h8, P + 32'h0C, 0);
        add(0, 1, P + 32'hFC, 1, B0, P + 32'hFC, P + 32'h100, 0);
        add(0, 0, 0,        0, B0,   P + 32'hFC, P + 32'h10C, 1);
        add(0, 0, 0,        0, B0,   P,         P + 32'h04, 0);

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].inst, tbl[i].pc, 1'b0, 1'b0, tbl[i].rst);
            upd_valid_i = tbl[i].uv;
            upd_pc_i    = tbl[i].upc;
            upd_taken_i = tbl[i].ut;
            chk($sformatf("vec%0d", i), tbl[i].exp_pc, tbl[i].exp_tk);
            tick();
        end
        reset = 1'b0;

        // Flush never touches the BHT.
        drive(B0, P, 1'b0, 1'b1, 1'b0);
        upd_valid_i = 1'b1; upd_pc_i = P; upd_taken_i = 1'b1;
        chk("flush_upd_before", P + 32'h04, 1'b0);
        tick();
        drive(B0, P, 1'b0, 1'b0, 1'b0);
        chk("flush_upd_after", P + 32'h10, 1'b1);
        tick();

`ifdef YSYX_23060251_RAS_EN
        do_reset();
        drive(JP8, P + 32'h100, 1'b1, 1'b0, 1'b0); chk("call", P + 32'h108, 1'b1); tick();
        drive(RET, P + 32'h500, 1'b1, 1'b0, 1'b0); chk("ret1", P + 32'h104, 1'b1); tick();
        drive(RET, P + 32'h500, 1'b1, 1'b0, 1'b0); chk("ret_empty", P + 32'h504, 1'b0); tick();

        // Five calls into a four-deep stack: oldest return is lost.
        exp_q.delete();
        for (int k = 1; k <= 5; k++) begin
            drive(JP8, 32'(k * 16), 1'b1, 1'b0, 1'b0);
            chk($sformatf("deep_call%0d", k), 32'(k * 16) + 32'h8, 1'b1);
            tick();
            exp_q.push_back(32'(k * 16) + 32'h4);
            if (exp_q.size() > 4) void'(exp_q.pop_front());
        end
        while (exp_q.size() > 0) begin
            logic [31:0] e;
            e = exp_q.pop_back();
            drive(RET, 32'h900, 1'b1, 1'b0, 1'b0); chk("deep_ret", e, 1'b1); tick();
        end
        drive(RET, 32'h900, 1'b1, 1'b0, 1'b0); chk("deep_ret_empty", 32'h904, 1'b0); tick();

        // if_valid_i gates the pop but not the prediction; x5 works as link too.
        drive(J5P8, P + 32'h100, 1'b1, 1'b0, 1'b0); chk("call_x5", P + 32'h108, 1'b1); tick();
        drive(RET5, P + 32'h600, 1'b0, 1'b0, 1'b0); chk("ret_novalid", P + 32'h104, 1'b1); tick();
        drive(RET5, P + 32'h600, 1'b1, 1'b0, 1'b0); chk("ret_x5", P + 32'h104, 1'b1); tick();

        // Flush wins over a pop and over a push.
        drive(JP8, P + 32'h100, 1'b1, 1'b0, 1'b0); tick();
        drive(RET, P + 32'h700, 1'b1, 1'b1, 1'b0); chk("flush_pop_pred", P + 32'h104, 1'b1); tick();
        drive(RET, P + 32'h700, 1'b1, 1'b0, 1'b0); chk("after_flush", P + 32'h704, 1'b0); tick();
        drive(JP8, P + 32'h100, 1'b1, 1'b1, 1'b0); tick();
        drive(RET, P + 32'h700, 1'b1, 1'b0, 1'b0); chk("flush_push", P + 32'h704, 1'b0); tick();

        // jalr x1,0(x5) replaces the top; jalr x1,0(x1) only pushes.
        drive(JP8, P + 32'h100, 1'b1, 1'b0, 1'b0); tick();
        drive(JP8, P + 32'h200, 1'b1, 1'b0, 1'b0); tick();
        drive(JR15, P + 32'h300, 1'b1, 1'b0, 1'b0); chk("swap_pred", P + 32'h204, 1'b1); tick();
        drive(RET, P + 32'h800, 1'b1, 1'b0, 1'b0); chk("swap_top", P + 32'h304, 1'b1); tick();
        drive(RET, P + 32'h800, 1'b1, 1'b0, 1'b0); chk("swap_next", P + 32'h104, 1'b1); tick();
        drive(JR11, P + 32'h400, 1'b1, 1'b0, 1'b0); chk("push_only", P + 32'h404, 1'b0); tick();
        drive(RET, P + 32'h800, 1'b1, 1'b0, 1'b0); chk("push_only_ret", P + 32'h404, 1'b1); tick();

        // Reset dominates a same-cycle push.
        drive(JP8, P + 32'h100, 1'b1, 1'b0, 1'b0); tick();
        drive(JP8, P + 32'h200, 1'b1, 1'b0, 1'b1); tick();
        drive(RET, P + 32'h800, 1'b1, 1'b0, 1'b0); chk("reset_push", P + 32'h804, 1'b0); tick();
`else
        drive(JP8, P + 32'h100, 1'b1, 1'b0, 1'b0); chk("call", P + 32'h108, 1'b1); tick();
        drive(RET, P + 32'h500, 1'b1, 1'b0, 1'b0); chk("ret_noras", P + 32'h504, 1'b0); tick();
        drive(JR15, P + 32'h300, 1'b1, 1'b0, 1'b0); chk("jalr_noras", P + 32'h304, 1'b0); tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bpu_pred.md
BPU_PRED -- requirements
Module: bpu_pred

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC width in bits.
REQ-002 SHALL have parameter BHT_DEPTH, default 64, number of branch history entries; power of two, at least 2.
REQ-003 SHALL have parameter RAS_DEPTH, default 4, number of return-address-stack entries; at least 1.
REQ-004 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port inst_i, input, 32, fetched instruction.
REQ-007 SHALL have port pc_i, input, XLEN, PC of inst_i.
REQ-008 SHALL have port if_valid_i, input, 1, inst_i/pc_i valid; qualifies all RAS push/pop.
REQ-009 SHALL have port pred_pc_o, output, XLEN, predicted next PC.
REQ-010 SHALL have port pred_taken_o, output, 1, high when pred_pc_o is not pc_i+4.
REQ-011 SHALL have port upd_valid_i, input, 1, branch resolution valid.
REQ-012 SHALL have port upd_pc_i, input, XLEN, PC of the resolved branch.
REQ-013 SHALL have port upd_taken_i, input, 1, actual branch outcome.
REQ-014 SHALL have port flush_i, input, 1, pipeline redirect; empties the RAS.

Function
REQ-015 SHALL decode internally: branch opcode 1100011, jal 1101111, jalr 1100111; B and J immediates sign-extended to XLEN.
REQ-016 SHALL hold BHT_DEPTH 2-bit saturating counters, indexed by pc[log2(BHT_DEPTH)+1:2] for both lookup and update.
REQ-017 SHALL, for a branch, output pc_i+immB with pred_taken_o=1 when counter[1]=1; otherwise output pc_i+4 with pred_taken_o=0.
REQ-018 SHALL, for jal, always output pc_i+immJ with pred_taken_o=1.
REQ-019 SHALL, for all other instructions, output pc_i+4 with pred_taken_o=0, unless REQ-026 applies.
REQ-020 SHALL make prediction combinational in pc_i/inst_i, with zero-cycle latency and no dependence on if_valid_i.
REQ-021 SHALL, on upd_valid_i, increment the indexed counter when taken and decrement it when not taken, saturating at 3 and 0; the new value is visible the next cycle.
REQ-022 SHALL, when the same index is looked up and updated in the same cycle, predict from the old value (no bypass).
REQ-023 SHALL wrap all PC arithmetic modulo 2^XLEN.

Reset
REQ-024 SHALL, while reset is high at a clock edge, set every BHT counter to 2'b01 (weakly not-taken) and empty the RAS (count 0, pointer 0); reset dominates upd_valid_i, flush_i and push/pop.
REQ-025 SHALL keep outputs purely combinational, so that after reset every branch predicts pc_i+4 with pred_taken_o=0.

Configuration
REQ-026 SHALL, with macro YSYX_23060251_RAS_EN defined, include a RAS with the following behaviour (link register = x1 or x5):
  - push pc_i+4: if_valid_i and (jal or jalr) with rd=link.
  - pop: if_valid_i and jalr with rs1=link and rd not link.
  - pop then push (replace top): jalr with rd=link, rs1=link, rd!=rs1.
  - push only: jalr with rd=rs1=link.
  - prediction: on any pop-qualifying jalr with the RAS non-empty, pred_pc_o=top, pred_taken_o=1; RAS empty gives pc_i+4 with no state change.
  - full push: overwrites the oldest entry circularly; count saturates at RAS_DEPTH.
  - flush_i: empties the RAS and wins over a same-cycle push/pop.
REQ-027 SHALL, without YSYX_23060251_RAS_EN, contain no RAS storage, predict every jalr as pc_i+4 with pred_taken_o=0, and ignore flush_i.

Verification
REQ-028 SHALL pass: after reset, inst beq offset +16 at pc 0x80000000 -> pred_pc_o 0x80000004, pred_taken_o 0.
REQ-029 SHALL pass: two upd_valid_i taken at pc 0x80000000, then lookup of the same beq -> pred_pc_o 0x80000010, pred_taken_o 1; four further not-taken updates -> 0x80000004, and the counter stays at 0.
REQ-030 SHALL pass: jal x1,-8 at pc 0x80000100 -> pred_pc_o 0x800000F8, pred_taken_o 1.
REQ-031 SHALL pass (RAS_EN): jal x1 at 0x80000100, then ret (jalr x0,0(x1)) -> pred_pc_o 0x80000104; a second ret with the RAS empty -> pc_i+4, pred_taken_o 0.
REQ-032 SHALL pass (RAS_EN, RAS_DEPTH 4): five calls at 0x10,0x20,0x30,0x40,0x50, then four rets -> 0x54,0x44,0x34,0x24, and a fifth ret -> pc_i+4.
REQ-033 SHALL pass: reset asserted in the same cycle as upd_valid_i taken and a RAS push -> next cycle all counters 01 and the RAS empty.
